// File: rtl/ldpc_encoder_pkg.sv
// Shared types and helpers for the quasi-cyclic LDPC encoder (package ldpc_pkg).
package ldpc_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        PARITY  = 1'b1
    } state_t;

    // Widest circulant the rotate helper supports.
    localparam int MAX_W  = 64;
    localparam int KB_DEF = 4;
    localparam int MB_DEF = 4;

    // One counter indexes both info words and parity words, so size it for the larger of the two.
    function automatic int cnt_width(input int kb, input int mb);
        int n;
        n = (kb > mb) ? kb : mb;
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int CNT_W = cnt_width(KB_DEF, MB_DEF);

    // Circulant shift applied to info word j for parity row m.
    function automatic int shift(input int j, input int m, input int width);
        return (2 * j + m) % width;
    endfunction

    // Rotate the low 'width' bits of x left by s (0 <= s < width); upper bits return zero.
    function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] x, input int s, input int width);
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] xm;
        mask = (width >= MAX_W) ? {MAX_W{1'b1}} : ((MAX_W'(1) << width) - MAX_W'(1));
        xm   = x & mask;
        return ((xm << s) | (xm >> (width - s))) & mask;
    endfunction

endpackage

// File: rtl/ldpc_encoder_if.sv
// Word-serial stream between an information-word source and the encoder.
// master = upstream source / consumer side, slave = the encoder.
interface ldpc_encoder_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] i_in_data;
    logic             i_in_valid;
    logic             o_in_ready;
    logic [WIDTH-1:0] o_out_data;
    logic             o_out_valid;
    logic             o_out_last;

    modport master (
        output i_in_data, i_in_valid,
        input  o_in_ready, o_out_data, o_out_valid, o_out_last
    );

    modport slave (
        input  i_in_data, i_in_valid,
        output o_in_ready, o_out_data, o_out_valid, o_out_last
    );
endinterface

// File: rtl/ldpc_encoder_parity_acc.sv
// Parity accumulator: MB rows of WIDTH bits, each XOR-folding a rotated copy of every info word.
module ldpc_parity_acc
    import ldpc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int MB    = 4,
    parameter int CW    = 2
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_data,
    input  logic [CW-1:0]    i_idx,
    input  logic             i_acc_en,
    input  logic             i_clr,
    input  logic [CW-1:0]    i_rd_idx,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [MB-1:0][WIDTH-1:0] acc;

    for (genvar m = 0; m < MB; m++) begin : g_row
        logic [MAX_W-1:0] rot_full;
        logic [WIDTH-1:0] rot;

        // Rotated copy of the incoming word for this parity row.
        always_comb begin
            rot_full = rotl(MAX_W'(i_data), shift(int'(i_idx), m, WIDTH), WIDTH);
            rot      = rot_full[WIDTH-1:0];
        end

        // Row accumulator: clear on reset / end of codeword, fold in on accept.
        always_ff @(posedge i_clock) begin
            if (i_reset || i_clr) begin
                acc[m] <= '0;
            end else if (i_acc_en) begin
                acc[m] <= acc[m] ^ rot;
            end
        end
    end

    // Read port for the parity phase; out-of-range indices read as zero.
    always_comb begin
        o_rd_data = '0;
        if (int'(i_rd_idx) < MB) begin
            o_rd_data = acc[i_rd_idx];
        end
    end

endmodule

// File: rtl/ldpc_encoder.sv
// Systematic QC-LDPC encoder: passes KB info words through with one cycle of latency,
// then emits MB parity words back-to-back. Optional sticky drop flag o_err under
// macro LDPC_ENCODER_ERR_EN.
module ldpc_encoder
    import ldpc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int KB    = 4,
    parameter int MB    = 4
) (
    input  logic          i_clock,
    input  logic          i_reset,
    ldpc_encoder_if.slave bus
`ifdef LDPC_ENCODER_ERR_EN
    ,
    output logic          o_err
`endif
);

    localparam int CW = cnt_width(KB, MB);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic             in_ready;
    logic             accept;
    logic             last_info;
    logic             last_par;
    logic [WIDTH-1:0] par_word;

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave COLLECT on the last info word, leave PARITY after the last parity word.
    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (last_info) state_nxt = PARITY;
            PARITY:  if (last_par)  state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    // FSM outputs and per-cycle control strobes.
    always_comb begin
        in_ready  = (state == COLLECT);
        accept    = in_ready && bus.i_in_valid;
        last_info = accept && (cnt == CW'(KB - 1));
        last_par  = (state == PARITY) && (cnt == CW'(MB - 1));
    end

    assign bus.o_in_ready = in_ready;

    // Word counter: info index in COLLECT, parity index in PARITY.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cnt <= '0;
        end else if (state == COLLECT) begin
            if (accept) cnt <= last_info ? '0 : cnt + CW'(1);
        end else begin
            cnt <= last_par ? '0 : cnt + CW'(1);
        end
    end

    ldpc_parity_acc #(
        .WIDTH (WIDTH),
        .MB    (MB),
        .CW    (CW)
    ) u_acc (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_data   (bus.i_in_data),
        .i_idx    (cnt),
        .i_acc_en (accept),
        .i_clr    (last_par),
        .i_rd_idx (cnt),
        .o_rd_data(par_word)
    );

    // Output register: info word on accept, parity word every PARITY cycle.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            bus.o_out_data  <= '0;
            bus.o_out_valid <= 1'b0;
            bus.o_out_last  <= 1'b0;
        end else if (state == COLLECT) begin
            bus.o_out_valid <= accept;
            bus.o_out_last  <= 1'b0;
            if (accept) bus.o_out_data <= bus.i_in_data;
        end else begin
            bus.o_out_data  <= par_word;
            bus.o_out_valid <= 1'b1;
            bus.o_out_last  <= last_par;
        end
    end

`ifdef LDPC_ENCODER_ERR_EN
    // Sticky flag: a word was offered while the encoder was busy with parity.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_err <= 1'b0;
        end else if (bus.i_in_valid && !in_ready) begin
            o_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ldpc_encoder.sv
// Scoreboard bench for ldpc_encoder: driver predicts every output word (and its cycle),
// monitor pops and compares whenever the encoder presents a valid word.
module tb_ldpc_encoder;

    localparam int W  = 8;
    localparam int KB = 4;
    localparam int MB = 4;

    logic i_clock = 1'b0;
    logic i_reset = 1'b1;

    ldpc_encoder_if #(.WIDTH(W)) bus ();

`ifdef LDPC_ENCODER_ERR_EN
    logic o_err;
`endif

    ldpc_encoder #(.WIDTH(W), .KB(KB), .MB(MB)) dut (
        .i_clock(i_clock),
        .i_reset(i_reset),
        .bus    (bus)
`ifdef LDPC_ENCODER_ERR_EN
        ,
        .o_err  (o_err)
`endif
    );

    always #5 i_clock = ~i_clock;

    int cyc = 0;
    always @(posedge i_clock) cyc++;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
        int           at;
    } exp_t;

    exp_t         sbq[$];
    logic [W-1:0] words[$];
    int           nchk     = 0;
    int           nerr     = 0;
    int           ready_at = 0;
    bit           err_m    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference rotate: s single-bit left rotations of a W-bit value.
    function automatic logic [W-1:0] ref_rotl(input logic [W-1:0] x, input int s);
        int v;
        v = int'(x);
        for (int k = 0; k < s; k++) v = ((v << 1) | (v >> (W - 1))) & ((1 << W) - 1);
        return W'(v);
    endfunction

    // Drive one cycle of input and predict the encoder's response.
    task automatic step(input bit v, input logic [W-1:0] d);
        bit rdy;
        logic [W-1:0] p;
        @(negedge i_clock);
        bus.i_in_valid = v;
        bus.i_in_data  = d;
        rdy = (cyc >= ready_at);
        chk("in_ready", 32'(bus.o_in_ready), 32'(rdy));
`ifdef LDPC_ENCODER_ERR_EN
        chk("o_err", 32'(o_err), 32'(err_m));
        if (v && !rdy) err_m = 1'b1;
`endif
        if (v && rdy) begin
            sbq.push_back('{d, 1'b0, cyc + 1});
            words.push_back(d);
            if (words.size() == KB) begin
                for (int m = 0; m < MB; m++) begin
                    p = '0;
                    for (int j = 0; j < KB; j++) p ^= ref_rotl(words[j], (2 * j + m) % W);
                    sbq.push_back('{p, (m == MB - 1), cyc + 2 + m});
                end
                words.delete();
                ready_at = cyc + MB + 1;
            end
        end
    endtask

    task automatic cw(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] c, input logic [W-1:0] d);
        step(1'b1, a);
        step(1'b1, b);
        step(1'b1, c);
        step(1'b1, d);
    endtask

    task automatic drain();
        @(negedge i_clock);
        bus.i_in_valid = 1'b0;
        for (int i = 0; i < 50 && sbq.size() > 0; i++) @(negedge i_clock);
        chk("drain_empty", 32'(sbq.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge i_clock);
        i_reset        = 1'b1;
        bus.i_in_valid = 1'b0;
        @(negedge i_clock);
        i_reset = 1'b0;
        words.delete();
        sbq.delete();
        ready_at = 0;
        err_m    = 1'b0;
    endtask

    // Monitor: every valid output must match the head of the scoreboard, on time.
    always @(posedge i_clock) begin
        exp_t e;
        #1;
        if (!i_reset) begin
            if (bus.o_out_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("out_data", 32'(bus.o_out_data), 32'(e.data));
                    chk("out_last", 32'(bus.o_out_last), 32'(e.last));
                    chk("out_cycle", 32'(cyc), 32'(e.at));
                end
            end else if (sbq.size() > 0 && sbq[0].at <= cyc) begin
                e = sbq.pop_front();
                chk("out_valid_missing", 32'd0, 32'd1);
            end
        end
    end

    initial begin
        bus.i_in_valid = 1'b0;
        bus.i_in_data  = '0;
        repeat (2) @(negedge i_clock);
        i_reset = 1'b0;
        chk("rst_out_valid", 32'(bus.o_out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.o_out_data), 32'd0);
        chk("rst_out_last", 32'(bus.o_out_last), 32'd0);
        chk("rst_in_ready", 32'(bus.o_in_ready), 32'd1);
`ifdef LDPC_ENCODER_ERR_EN
        chk("rst_o_err", 32'(o_err), 32'd0);
`endif

        // Directed codewords: zero, unit impulses, linearity, all-ones.
        cw(8'h00, 8'h00, 8'h00, 8'h00); drain();
        cw(8'h01, 8'h00, 8'h00, 8'h00); drain();
        cw(8'h00, 8'h01, 8'h00, 8'h00); drain();
        cw(8'h01, 8'h01, 8'h00, 8'h00); drain();
        cw(8'hFF, 8'hFF, 8'hFF, 8'hFF); drain();

        // Valid held high over three codewords: stalls during parity, continuous output.
        repeat (3 * (KB + MB)) step(1'b1, W'($urandom));
        drain();

        // Reset mid-codeword discards the partial word set; next codeword starts at word 0.
        step(1'b1, 8'h33);
        step(1'b1, 8'h44);
        do_reset();
        cw(8'h01, 8'h00, 8'h00, 8'h00); drain();

        // Random data with random gaps between accepted words.
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < KB; j++) begin
                repeat ($urandom_range(0, 2)) step(1'b0, W'($urandom));
                step(1'b1, W'($urandom));
            end
            repeat ($urandom_range(0, 3)) step(1'b0, W'($urandom));
        end
        drain();

        // Unit impulse again, this time spread out with gaps.
        step(1'b1, 8'h01); step(1'b0, 8'hAA);
        step(1'b1, 8'h00); step(1'b0, 8'h55); step(1'b0, 8'h55);
        step(1'b1, 8'h00);
        step(1'b1, 8'h00);
        drain();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/ldpc_encoder.md
Name: ldpc_encoder

Overview:
Systematic quasi-cyclic LDPC encoder. It is the transmit-side counterpart of ldpc_decoder and uses the same word-serial valid-qualified stream. It accepts KB information words of WIDTH bits and forwards each one unchanged with 1-cycle latency. It then appends MB parity words, computed by XOR-accumulating circulant-rotated copies of each information word.

Parameters:
WIDTH, 8, word width and circulant size Z in bits
KB, 4, information words per codeword
MB, 4, parity words per codeword

Ports:
i_clock  in  1  clock; all logic on rising edge
i_reset  in  1  synchronous, active-high reset
i_in_data  in  WIDTH  information word
i_in_valid  in  1  i_in_data valid; a word is accepted when i_in_valid && o_in_ready
o_in_ready  out  1  encoder accepting information words
o_out_data  out  WIDTH  codeword word (info words, then parity words)
o_out_valid  out  1  o_out_data valid; no backpressure, the consumer must always accept
o_out_last  out  1  high with the final parity word of each codeword

Behaviour:
- Interface: one clock, i_clock. Reset i_reset is synchronous, active-high.
- Reset values: o_out_data=0, o_out_valid=0, o_out_last=0, state=COLLECT, word counter=0, parity accumulator acc[0..MB-1]=0. o_in_ready=1 from the first cycle after reset deasserts.
- State COLLECT:
  - o_in_ready=1.
  - On acceptance of word j (counter value j): register o_out_data<=i_in_data, o_out_valid<=1, o_out_last<=0.
  - For each m in 0..MB-1: acc[m] <= acc[m] XOR rotl(i_in_data, shift(j,m)).
  - Counter increments. When j==KB-1, the counter clears and state goes to PARITY.
  - Cycles with no acceptance: o_out_valid<=0, acc holds.
- State PARITY:
  - o_in_ready=0.
  - Each cycle c=0..MB-1 registers o_out_data<=acc[c], o_out_valid<=1, o_out_last<=(c==MB-1).
  - After c==MB-1: all acc cleared, counter cleared, state goes to COLLECT.
- Rotation rule: rotl(x,s) bit i = x[(i-s) mod WIDTH]. shift(j,m) = (2*j+m) mod WIDTH.
- Latency:
  - Info word accepted in cycle t appears on o_out_data at t+1.
  - If the last info word is accepted at t, parity words appear at t+2..t+1+MB, contiguous with no gaps.
  - o_in_ready is low for cycles t+1..t+MB and high again at t+MB+1.
- Gaps: input gaps between info words are allowed and pass through as o_out_valid=0 gaps. The codeword is only sized by the count of accepted words.
- Input during PARITY: i_in_valid while o_in_ready=0 is ignored and the data is not captured.
- Reset mid-codeword: any partial codeword is discarded with no parity emitted. The first accepted word after reset is word 0.
- Back-to-back codewords: with i_in_valid held high, the encoder accepts KB words, stalls MB cycles, then accepts the next KB words. Output is continuous: KB+MB valid words per codeword.

Optional Feature:
Macro LDPC_ENCODER_ERR_EN.
- Defined:
  - Adds output o_err (1 bit).
  - o_err is a sticky flag, set on the cycle after any cycle with i_in_valid=1 && o_in_ready=0 (dropped word).
  - Cleared only by i_reset; reset value 0.
- Not defined: port absent, no extra logic, behaviour otherwise identical.

Decomposition:
- Package ldpc_pkg holds:
  - the state enum (COLLECT, PARITY);
  - function shift(j,m,width);
  - function rotl(x,s) generic over WIDTH via a parameterized class or width argument;
  - localparam for the counter width, $clog2(max(KB,MB)).
- Natural sub-module: ldpc_parity_acc. It holds the MB×WIDTH accumulator array and takes inputs: data, word index, accumulate enable, clear, read index. It outputs the selected parity word. The FSM and output registers stay in ldpc_encoder.

Test Plan:
- All-zero codeword (4 words of 0x00) -> outputs 0x00×4 then parity 0x00,0x00,0x00,0x00; o_out_last on 8th word only.
- Word0=0x01, words1..3=0x00 -> parity 0x01,0x02,0x04,0x08.
- Word1=0x01 only -> parity 0x04,0x08,0x10,0x20. Words0=0x01 and 1=0x01 -> parity 0x05,0x0A,0x14,0x28 (linearity).
- All words 0xFF -> parity 0x00×4. i_in_valid held high across 3 codewords -> o_in_ready pattern 1111 0000 repeating; 24 contiguous valid outputs; info latency exactly 1 cycle.
- Assert i_reset after 2 info words -> no parity output. The next 4 words encode as a fresh codeword (repeat the 0x01 vector, expect 0x01,0x02,0x04,0x08). Random gaps inside a codeword give identical parity.
- With LDPC_ENCODER_ERR_EN: drive i_in_valid=1 during PARITY -> o_err=1 the next cycle, stays 1 until reset, and data is unaffected. Without the macro: same stimulus, data identical, no o_err port.
